uart_apb_sequencer: RTL



---
 rtl/uart_seq_pkg.sv | 43 ++++
 rtl/uart_apb_sequencer_if.sv | 23 ++
 rtl/uart_seq_err_cnt.sv | 41 ++++
 rtl/uart_apb_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART APB sequencer: FSM state encoding,
// UART register offsets, STATUS bit positions and small helpers.
package uart_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CFG1_S,
        CFG1_A,
        CFG2_S,
        CFG2_A,
        POLL_S,
        POLL_A,
        RX_S,
        RX_A,
        TX_S,
        TX_A
    } state_e;

    // Byte addresses of the UART registers (PADDR[1:0] is always zero)
    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    // STATUS register bit positions
    localparam int unsigned STATUS_TXRDY       = 0;
    localparam int unsigned STATUS_RXRDY       = 1;
    localparam int unsigned STATUS_PARITY_ERR  = 2;
    localparam int unsigned STATUS_OVERFLOW    = 3;
    localparam int unsigned STATUS_FRAMING_ERR = 4;

    // True for the APB access-phase states (PENABLE high)
    function automatic logic is_access(input state_e s);
        return (s == CFG1_A) || (s == CFG2_A) || (s == POLL_A) || (s == RX_A) || (s == TX_A);
    endfunction

    // Increment that sticks at 255
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_apb_sequencer_if.sv
// APB bus between the sequencer (master) and the UART register block (slave).
interface uart_apb_sequencer_if;

    logic [4:0] PADDR;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/uart_seq_err_cnt.sv
// Saturating error-event counters fed by successive STATUS poll samples.
// A counter steps when its STATUS bit goes 0->1 between two polls; the first
// poll after reset compares against an all-zero history.
module uart_seq_err_cnt
    import uart_seq_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       sample_en,
    input  logic [7:0] status,
    output logic [7:0] parity_cnt,
    output logic [7:0] framing_cnt,
    output logic [7:0] overflow_cnt
);

    // {framing, overflow, parity}
    logic [2:0] cur;
    logic [2:0] prev_q;
    logic [2:0] rise;
    logic       unused_status;

    assign cur  = {status[STATUS_FRAMING_ERR], status[STATUS_OVERFLOW], status[STATUS_PARITY_ERR]};
    assign rise = cur & ~prev_q;
    assign unused_status = ^{status[7:5], status[STATUS_RXRDY], status[STATUS_TXRDY]};

    // Edge history and counters, updated once per completed poll
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prev_q       <= 3'b000;
            parity_cnt   <= 8'h00;
            overflow_cnt <= 8'h00;
            framing_cnt  <= 8'h00;
        end else if (sample_en) begin
            prev_q <= cur;
            if (rise[0]) parity_cnt   <= sat_inc(parity_cnt);
            if (rise[1]) overflow_cnt <= sat_inc(overflow_cnt);
            if (rise[2]) framing_cnt  <= sat_inc(framing_cnt);
        end
    end

endmodule

// File: rtl/uart_apb_sequencer.sv
// APB master that configures a UART once after reset, then polls STATUS and
// moves single bytes between the UART and the tx/rx valid-ready streams.
// Optional build macro UART_SEQ_ERR_CNT_EN adds parity/framing/overflow
// event counters.
module uart_apb_sequencer
    import uart_seq_pkg::*;
#(
    parameter logic [12:0] BAUD_VALUE = 13'd0,
    parameter bit          BIT8       = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          ODD_N_EVEN = 1'b0
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    uart_apb_sequencer_if.master        apb,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        cfg_done
`ifdef UART_SEQ_ERR_CNT_EN
    ,
    output logic [7:0]                  parity_cnt,
    output logic [7:0]                  framing_cnt,
    output logic [7:0]                  overflow_cnt
`endif
);

    localparam logic [7:0] CTRL1_DATA = BAUD_VALUE[7:0];
    localparam logic [7:0] CTRL2_DATA = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};

    state_e     state_q, state_d;
    // Setup state entered after the one-cycle IDLE gap
    state_e     target_q, target_d;
    logic [7:0] tx_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       cfg_done_q;
    logic       unused_slverr;

    assign unused_slverr = apb.PSLVERR;

    // State and gap-target registers; reset aborts any transfer in flight
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= IDLE;
            target_q <= CFG1_S;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Next-state: every transfer is S -> A (held until PREADY) -> IDLE -> next S
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            IDLE:   state_d = target_q;
            CFG1_S: state_d = CFG1_A;
            CFG1_A: if (apb.PREADY) begin
                state_d  = IDLE;
                target_d = CFG2_S;
            end
            CFG2_S: state_d = CFG2_A;
            CFG2_A: if (apb.PREADY) begin
                state_d  = IDLE;
                target_d = POLL_S;
            end
            POLL_S: state_d = POLL_A;
            POLL_A: if (apb.PREADY) begin
                state_d = IDLE;
                // RX wins; no RXDATA read while the previous byte is unconsumed
                if (apb.PRDATA[STATUS_RXRDY] && !rx_valid_q) begin
                    target_d = RX_S;
                end else if (apb.PRDATA[STATUS_TXRDY] && tx_valid) begin
                    target_d = TX_S;
                end else begin
                    target_d = POLL_S;
                end
            end
            RX_S:   state_d = RX_A;
            RX_A:   if (apb.PREADY) begin
                state_d  = IDLE;
                target_d = POLL_S;
            end
            TX_S:   state_d = TX_A;
            TX_A:   if (apb.PREADY) begin
                state_d  = IDLE;
                target_d = POLL_S;
            end
            default: begin
                state_d  = IDLE;
                target_d = CFG1_S;
            end
        endcase
    end

    // APB outputs decoded from the current state; address/data fixed per transfer
    always_comb begin
        apb.PSEL    = (state_q != IDLE);
        apb.PENABLE = is_access(state_q);
        apb.PWRITE  = 1'b0;
        apb.PADDR   = ADDR_TXDATA;
        apb.PWDATA  = 8'h00;
        tx_ready    = 1'b0;
        case (state_q)
            CFG1_S, CFG1_A: begin
                apb.PWRITE = 1'b1;
                apb.PADDR  = ADDR_CTRL1;
                apb.PWDATA = CTRL1_DATA;
            end
            CFG2_S, CFG2_A: begin
                apb.PWRITE = 1'b1;
                apb.PADDR  = ADDR_CTRL2;
                apb.PWDATA = CTRL2_DATA;
            end
            POLL_S, POLL_A: apb.PADDR = ADDR_STATUS;
            RX_S, RX_A:     apb.PADDR = ADDR_RXDATA;
            TX_S: begin
                // Byte is taken this cycle, so drive it straight through
                tx_ready   = 1'b1;
                apb.PWRITE = 1'b1;
                apb.PWDATA = tx_data;
            end
            TX_A: begin
                apb.PWRITE = 1'b1;
                apb.PWDATA = tx_q;
            end
            default: ;
        endcase
    end

    // Datapath: TX byte latch, RX holding register, configuration flag
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_q       <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            if (state_q == TX_S) tx_q <= tx_data;
            if (state_q == RX_A && apb.PREADY) begin
                rx_data_q  <= apb.PRDATA;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (state_q == CFG2_A && apb.PREADY) cfg_done_q <= 1'b1;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign cfg_done = cfg_done_q;

`ifdef UART_SEQ_ERR_CNT_EN
    logic poll_done;
    assign poll_done = (state_q == POLL_A) && apb.PREADY;

    uart_seq_err_cnt u_err_cnt (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .sample_en    (poll_done),
        .status       (apb.PRDATA),
        .parity_cnt   (parity_cnt),
        .framing_cnt  (framing_cnt),
        .overflow_cnt (overflow_cnt)
    );
`endif

endmodule
